// File: rtl/jtag_bsr_param_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bsr_param_if
// Brief    : TAP strobes, serial data and pin/core buses of the boundary-scan
//            register, bundled for the BSR (slave) and its driver (master).
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_bsr_param_if #(
  parameter int NUM_IN  = 36,
  parameter int NUM_OUT = 39
);
  localparam int CNT_W = $clog2(NUM_IN + NUM_OUT + 1);

  logic               clockdr;
  logic               shiftdr;
  logic               updatedr;
  logic [1:0]         inst;
  logic               TDI;
  logic               TDO;
  logic [NUM_IN-1:0]  pin_in;
  logic [NUM_IN-1:0]  core_in;
  logic [NUM_OUT-1:0] core_out;
  logic [NUM_OUT-1:0] pin_out;
  logic [CNT_W-1:0]   shift_cnt;

  modport master (
    output clockdr, shiftdr, updatedr, inst, TDI, pin_in, core_out,
    input  TDO, core_in, pin_out, shift_cnt
  );

  modport slave (
    input  clockdr, shiftdr, updatedr, inst, TDI, pin_in, core_out,
    output TDO, core_in, pin_out, shift_cnt
  );
endinterface
`default_nettype wire

// File: rtl/jtag_bsr_param.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bsr_param
// Brief    : Parametrised boundary-scan chain (input cells, output cells,
//            bypass bit) with EXTEST / SAMPLE / BYPASS / INTEST muxing.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_bsr_param #(
  parameter int NUM_IN     = 36,
  parameter int NUM_OUT    = 39,
  parameter bit SAFE_VALUE = 1'b0
) (
  input  logic             TCLK,
  input  logic             TRST,
  jtag_bsr_param_if.slave  bus
);

  localparam int c_len   = NUM_IN + NUM_OUT;
  localparam int c_cnt_w = $clog2(c_len + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_len);

  localparam logic [1:0] c_extest = 2'b00;
  localparam logic [1:0] c_sample = 2'b01;
  localparam logic [1:0] c_bypass = 2'b10;
  localparam logic [1:0] c_intest = 2'b11;

  // Bit 0 is in[0] (next to TDI); bit c_len-1 is out[NUM_OUT-1] (drives TDO).
  logic [c_len-1:0]   r_sh;
  logic [c_len-1:0]   r_up;
  logic               r_byp;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_byp;

  assign w_byp = (bus.inst == c_bypass);

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      r_sh  <= '0;
      r_up  <= '0;
      r_byp <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (bus.shiftdr) begin
        if (w_byp) begin
          r_byp <= bus.TDI;
        end else begin
          r_sh <= {r_sh[c_len-2:0], bus.TDI};
          if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
      end else if (bus.clockdr) begin
        if (w_byp) begin
          r_byp <= 1'b0;
        end else begin
          r_sh  <= {bus.core_out, bus.pin_in};
          r_cnt <= '0;
        end
      end
      // Non-blocking read of r_sh gives the pre-edge contents even when shifting.
      if (bus.updatedr && !w_byp) begin
        r_up <= r_sh;
      end
    end
  end

  always_comb begin
    bus.core_in = bus.pin_in;
    bus.pin_out = bus.core_out;
    case (bus.inst)
      c_extest: bus.pin_out = r_up[c_len-1:NUM_IN];
      c_intest: begin
        bus.core_in = r_up[NUM_IN-1:0];
        bus.pin_out = {NUM_OUT{SAFE_VALUE}};
      end
      c_sample, c_bypass: begin
      end
      default: begin
      end
    endcase
  end

  assign bus.TDO       = w_byp ? r_byp : r_sh[c_len-1];
  assign bus.shift_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bsr_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_bsr_param
// Brief    : Directed bench for jtag_bsr_param (NUM_IN=4, NUM_OUT=3) with a
//            queue-based scoreboard sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_bsr_param;

  localparam int K_TDO = 0;
  localparam int K_CNT = 1;
  localparam int K_CIN = 2;
  localparam int K_PIN = 3;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  logic tclk;
  logic trst;
  logic [3:0] nxt_pin;
  logic [2:0] nxt_core;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  jtag_bsr_param_if #(.NUM_IN(4), .NUM_OUT(3)) bus ();

  jtag_bsr_param #(.NUM_IN(4), .NUM_OUT(3), .SAFE_VALUE(1'b1)) dut (
    .TCLK (tclk),
    .TRST (trst),
    .bus  (bus.slave)
  );

  initial begin
    tclk = 1'b0;
    forever #5 tclk = ~tclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1);
  end

  task automatic push_exp(input string name, input int kind, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic apply(input logic [1:0] ins, input logic c, input logic s,
                       input logic u, input logic t);
    @(negedge tclk);
    #1;
    trst         = 1'b0;
    bus.inst     = ins;
    bus.clockdr  = c;
    bus.shiftdr  = s;
    bus.updatedr = u;
    bus.TDI      = t;
    bus.pin_in   = nxt_pin;
    bus.core_out = nxt_core;
    @(posedge tclk);
    #1;
  endtask

  // Monitor: every falling edge, compare all pending expectations.
  always @(negedge tclk) begin : mon
    exp_t       e;
    logic [7:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_TDO:   act = {7'b0, bus.TDO};
        K_CNT:   act = 8'(bus.shift_cnt);
        K_CIN:   act = 8'(bus.core_in);
        default: act = 8'(bus.pin_out);
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b, expected %b", e.name, act, e.exp);
      end
    end
  end

  initial begin : stim
    logic [6:0] vec;
    trst         = 1'b1;
    bus.inst     = 2'b00;
    bus.clockdr  = 1'b0;
    bus.shiftdr  = 1'b0;
    bus.updatedr = 1'b0;
    bus.TDI      = 1'b0;
    nxt_pin      = 4'b0101;
    nxt_core     = 3'b111;
    bus.pin_in   = nxt_pin;
    bus.core_out = nxt_core;

    // Reset state
    apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("rst_tdo", K_TDO, 8'd0);
    push_exp("rst_cnt", K_CNT, 8'd0);
    push_exp("rst_pin_out", K_PIN, 8'b000);
    push_exp("rst_core_in", K_CIN, 8'b0101);

    // Fill chain with ones, then reset mid-shift
    for (int i = 0; i < 7; i++) apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    push_exp("fill_tdo", K_TDO, 8'd1);
    push_exp("fill_cnt", K_CNT, 8'd7);
    @(negedge tclk);
    #1;
    bus.inst    = 2'b00;
    bus.shiftdr = 1'b1;
    bus.TDI     = 1'b1;
    #2;
    trst = 1'b1;
    #1;
    push_exp("midrst_tdo", K_TDO, 8'd0);
    push_exp("midrst_cnt", K_CNT, 8'd0);
    push_exp("midrst_core_in", K_CIN, 8'b0101);
    push_exp("midrst_pin_out", K_PIN, 8'b000);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    push_exp("post_rst_tdo", K_TDO, 8'd0);
    push_exp("post_rst_cnt", K_CNT, 8'd1);

    // SAMPLE
    nxt_pin  = 4'b1010;
    nxt_core = 3'b011;
    vec      = 7'b0111010;
    apply(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("sample_tdo0", K_TDO, {7'b0, vec[6]});
    push_exp("sample_cnt0", K_CNT, 8'd0);
    for (int k = 1; k < 7; k++) begin
      apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp($sformatf("sample_tdo%0d", k), K_TDO, {7'b0, vec[6-k]});
    end
    push_exp("sample_cnt6", K_CNT, 8'd6);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("sample_cnt7", K_CNT, 8'd7);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("cnt_saturate", K_CNT, 8'd7);

    // PRELOAD then EXTEST
    vec = 7'b1011001;
    for (int k = 0; k < 7; k++) apply(2'b01, 1'b0, 1'b1, 1'b0, vec[6-k]);
    push_exp("preload_tdo", K_TDO, 8'd1);
    apply(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp("sample_pin_out", K_PIN, 8'b011);
    nxt_pin = 4'b1100;
    apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("extest_pin_out", K_PIN, 8'b101);
    push_exp("extest_core_in", K_CIN, 8'b1100);

    // BYPASS
    nxt_pin  = 4'b0110;
    nxt_core = 3'b100;
    apply(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("byp_cap_tdo", K_TDO, 8'd0);
    push_exp("byp_pin_out", K_PIN, 8'b100);
    vec = 7'b0000101;
    for (int k = 0; k < 3; k++) begin
      apply(2'b10, 1'b0, 1'b1, 1'b0, vec[2-k]);
      push_exp($sformatf("byp_tdo%0d", k + 1), K_TDO, {7'b0, vec[2-k]});
    end
    apply(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp("byp_hold_tdo", K_TDO, 8'd1);
    apply(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("byp_cnt_kept", K_CNT, 8'd2);
    push_exp("byp_sh_tdo", K_TDO, 8'd0);
    apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("byp_up_kept", K_PIN, 8'b101);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("byp_sh_a", K_TDO, 8'd0);
    push_exp("byp_cnt_a", K_CNT, 8'd3);
    apply(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("byp_sh_b", K_TDO, 8'd1);
    push_exp("byp_cnt_b", K_CNT, 8'd4);

    // INTEST
    vec = 7'b0100110;
    for (int k = 0; k < 7; k++) apply(2'b01, 1'b0, 1'b1, 1'b0, vec[6-k]);
    apply(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("intest_core_in", K_CIN, 8'b0110);
    push_exp("intest_pin_out", K_PIN, 8'b111);
    nxt_pin  = 4'b1001;
    nxt_core = 3'b110;
    vec      = 7'b1101001;
    apply(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("intest_tdo0", K_TDO, {7'b0, vec[6]});
    push_exp("intest_core_in_hold", K_CIN, 8'b0110);
    for (int k = 1; k < 7; k++) begin
      apply(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp($sformatf("intest_tdo%0d", k), K_TDO, {7'b0, vec[6-k]});
    end

    // Simultaneous strobes: shift wins, update uses pre-edge chain
    nxt_pin  = 4'b0011;
    nxt_core = 3'b101;
    apply(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    push_exp("simul_tdo", K_TDO, 8'd0);
    push_exp("simul_cnt", K_CNT, 8'd1);
    apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("simul_up_out", K_PIN, 8'b101);
    apply(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("simul_up_in", K_CIN, 8'b0011);

    @(negedge tclk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtag_bsr_param.md
# jtag_bsr_param

Parametrised JTAG boundary-scan register placed between a core's primary I/O and the chip pins. It holds NUM_IN input cells and NUM_OUT output cells in one serial chain, plus a 1-bit bypass register. Cells capture, shift and update under TAP-controller strobes. Four instructions select EXTEST, SAMPLE/PRELOAD, BYPASS or INTEST pin/core muxing. A saturating shift counter lets the TAP controller or bench confirm that a full chain length was shifted.

## Interface
- NUM_IN, 36: number of input boundary cells (≥1).
- NUM_OUT, 39: number of output boundary cells (≥1).
- SAFE_VALUE, 0: 1-bit level driven on every pin_out during INTEST.
- TCLK  in  1  test clock; all state changes on its rising edge.
- TRST  in  1  asynchronous, active-high reset.
- clockdr  in  1  capture strobe (Capture-DR), one TCLK cycle.
- shiftdr  in  1  shift enable (Shift-DR).
- updatedr  in  1  update strobe (Update-DR), one TCLK cycle.
- inst  in  2  instruction: 00 EXTEST, 01 SAMPLE/PRELOAD, 10 BYPASS, 11 INTEST.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- pin_in  in  NUM_IN  chip input pins.
- core_in  out  NUM_IN  inputs to core.
- core_out  in  NUM_OUT  core outputs.
- pin_out  out  NUM_OUT  chip output pins.
- shift_cnt  out  $clog2(NUM_IN+NUM_OUT+1)  shifts since last capture, saturating at L = NUM_IN+NUM_OUT.

## Operation
- Chain order: TDI → in[0] … in[NUM_IN-1] → out[0] … out[NUM_OUT-1] → TDO. Index i of each cell maps to bit i of its bus.
- Each cell has a shift stage (sh) and an update latch (up). BYP is a separate 1-bit register.
- Priority at each edge: shift beats capture. Update is evaluated independently and uses the pre-edge sh values.
- Capture: applies when clockdr=1, shiftdr=0 and inst≠BYPASS.
  - Input cells: sh ← pin_in.
  - Output cells: sh ← core_out.
  - shift_cnt ← 0.
- Capture in BYPASS: BYP ← 0; the sh stages hold.
- Shift with inst≠BYPASS: every sh stage takes its upstream neighbour (in[0] takes TDI). shift_cnt increments, saturating at L. BYP holds.
- Shift with inst=BYPASS: BYP ← TDI; sh stages and shift_cnt hold.
- Update: applies when updatedr=1 and inst≠BYPASS; then up ← sh for all cells. In BYPASS the up latches hold.
- Muxing (combinational from inst and registers):
  - EXTEST: pin_out = up(out); core_in = pin_in.
  - SAMPLE/PRELOAD and BYPASS: pin_out = core_out; core_in = pin_in.
  - INTEST: core_in = up(in); pin_out = {NUM_OUT{SAFE_VALUE}}.
- TDO = BYP when inst=BYPASS, otherwise sh(out[NUM_OUT-1]). TDO is combinational from registers; no falling-edge retiming.
- Changing inst mid-shift never alters register contents; it changes only muxing, TDO source and which register shifts.

## Timing
- Reset (TRST=1, asynchronous): all sh=0, all up=0, BYP=0, shift_cnt=0. TDO is then 0. pin_out follows the muxing rules (0 in EXTEST, SAFE_VALUE in INTEST, core_out otherwise). Reset mid-shift discards partial data immediately. The first shift after reset deassertion acts on the cleared chain.
- Serial latency: a bit presented on TDI with shiftdr=1 at edge k appears on TDO after edge k+L-1 (BSR) or after edge k (BYPASS).
- Capture-to-TDO: after the capture edge, TDO shows the captured out[NUM_OUT-1] value. Successive shifts then present out[NUM_OUT-2] … in[0].
- Update-to-pin: pin_out/core_in reflect new up values immediately after the update edge; there is no extra cycle.
- Strobes held high for several cycles repeat their action each cycle. Idle (all strobes 0) holds all state.

## Test plan
Bench parameters: NUM_IN=4, NUM_OUT=3, SAFE_VALUE=1, L=7.
- Reset: assert TRST mid-shift with chain non-zero → TDO=0, shift_cnt=0, core_in=pin_in; with inst=00, pin_out=000.
- SAMPLE: pin_in=1010, core_out=011, pulse clockdr, then 7 shifts → TDO sequence starting right after capture: 0,1,1,1,0,1,0 (out[2] … out[0], then in[3] … in[0]). shift_cnt reads 7 and stays 7 after an 8th shift.
- PRELOAD/EXTEST: inst=01, shift TDI sequence 1,0,1,1,0,0,1 (first bit lands in out[2]), pulse updatedr, set inst=00 → pin_out=101 (out[2..0]=1,0,1), core_in=pin_in.
- BYPASS: inst=10, capture then TDI=1,0,1 → TDO 0,1,0,1 one cycle delayed. BSR sh, up and shift_cnt unchanged; updatedr has no effect.
- INTEST: preload in cells 0110, update, inst=11 → core_in=0110 and pin_out=111. Capture then shift 7 times → TDO shows core_out then pin_in.
- Simultaneous strobes: clockdr=shiftdr=updatedr=1 in one cycle → the chain shifts (no capture), and up receives the pre-edge sh contents.
